// File: rtl/if_stage_ctrl.sv
// Fetch stage controller: owns the PC, the IF/ID pipeline register and a
// BOOT/RUN/SQUASH redirect FSM driven by the hazard unit's stall/flush commands.
module if_stage_ctrl #(
    parameter int unsigned              DATA_WIDTH = 16,
    parameter int unsigned              ADDR_WIDTH = 16,
    parameter int unsigned              PC_INC     = 1,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0]    NOP_INSTR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pcstall,
    input  logic                  IF_IDstall,
    input  logic                  flushIF_ID,
    input  logic                  PCSrc,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    output logic                  imem_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [ADDR_WIDTH-1:0] pcF,
    output logic [DATA_WIDTH-1:0] instrD,
    output logic [ADDR_WIDTH-1:0] pcplus1D,
    output logic                  validD,
    output logic                  squashing,
    output logic [15:0]           squash_cnt
);

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_SQUASH = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] pcp1_q, pcp1_d;
    logic                  valid_q, valid_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  jump_stalled;
    logic                  flush_req;

    assign pc_inc       = pc_q + ADDR_WIDTH'(PC_INC);
    assign jump_stalled = jump && pcstall;
    // A stalled jump must survive a flush so it can be re-presented later.
    assign flush_req    = PCSrc || (flushIF_ID && !jump_stalled);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (PCSrc) state_d = ST_SQUASH;
            ST_SQUASH: if (!pcstall && !PCSrc) state_d = ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
    end

    // PC is frozen during BOOT; redirects only take effect once fetching.
    always_comb begin
        pc_d = pc_q;
        if (state_q != ST_BOOT) begin
            if (PCSrc)
                pc_d = branch_target;
            else if (jump && !pcstall)
                pc_d = jump_target;
            else if (!pcstall)
                pc_d = pc_inc;
        end
    end

    // In SQUASH, pcF already points at the redirect target, so an unstalled
    // fetch there is the target instruction and loads as a real one.
    always_comb begin
        instr_d = instr_q;
        pcp1_d  = pcp1_q;
        valid_d = valid_q;
        if (flush_req) begin
            instr_d = NOP_INSTR;
            pcp1_d  = pc_inc;
            valid_d = 1'b0;
        end else if (IF_IDstall || pcstall) begin
            instr_d = instr_q;
            pcp1_d  = pcp1_q;
            valid_d = valid_q;
        end else if (state_q == ST_BOOT) begin
            instr_d = NOP_INSTR;
            pcp1_d  = pc_inc;
            valid_d = 1'b0;
        end else begin
            instr_d = imem_rdata;
            pcp1_d  = pc_inc;
            valid_d = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_SQUASH && cnt_q != '1)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcp1_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp1_q  <= pcp1_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_en    = (state_q != ST_BOOT);
    assign imem_addr  = pc_q;
    assign pcF        = pc_q;
    assign instrD     = instr_q;
    assign pcplus1D   = pcp1_q;
    assign validD     = valid_q;
    assign squashing  = (state_q == ST_SQUASH);
    assign squash_cnt = cnt_q;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Bench for if_stage_ctrl: directed scenarios plus random traffic, all checked
// against a cycle-level reference model of the fetch-stage rules.
module tb_if_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst, pcstall, IF_IDstall, flushIF_ID, PCSrc, jump;
    logic [15:0] branch_target, jump_target;
    logic        imem_en;
    logic [15:0] imem_addr, imem_rdata, pcF, instrD, pcplus1D;
    logic        validD, squashing;
    logic [15:0] squash_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [15:0] m_pc, m_instr, m_p1, m_cnt;
    bit          m_valid, m_boot, m_sq;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return (a < 16'h0100) ? 16'(16'h1000 + a) : (a ^ 16'hA5A5);
    endfunction

    assign imem_rdata = mem_f(imem_addr);

    if_stage_ctrl #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .PC_INC     (1),
        .RESET_PC   (16'h0000),
        .NOP_INSTR  (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pcstall       (pcstall),
        .IF_IDstall    (IF_IDstall),
        .flushIF_ID    (flushIF_ID),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .pcF           (pcF),
        .instrD        (instrD),
        .pcplus1D      (pcplus1D),
        .validD        (validD),
        .squashing     (squashing),
        .squash_cnt    (squash_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pcF"},       pcF,        m_pc);
        check({tag, ".imem_addr"}, imem_addr,  m_pc);
        check({tag, ".imem_en"},   imem_en,    !m_boot);
        check({tag, ".instrD"},    instrD,     m_instr);
        check({tag, ".pcplus1D"},  pcplus1D,   m_p1);
        check({tag, ".validD"},    validD,     m_valid);
        check({tag, ".squashing"}, squashing,  m_sq);
        check({tag, ".squash_cnt"}, squash_cnt, m_cnt);
    endtask

    // One clock of the fetch-stage rules, evaluated on the inputs as driven.
    task automatic model_clock();
        logic [15:0] inc, npc, ninstr, np1;
        bit          nvalid, nboot, nsq;
        logic [15:0] ncnt;
        if (rst) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_p1 = 16'h0000;
            m_valid = 0; m_boot = 1; m_sq = 0; m_cnt = 16'h0000;
            return;
        end
        inc = 16'(m_pc + 16'd1);
        if (m_boot)                  npc = m_pc;
        else if (PCSrc)              npc = branch_target;
        else if (jump && !pcstall)   npc = jump_target;
        else if (pcstall)            npc = m_pc;
        else                         npc = inc;

        ninstr = m_instr; np1 = m_p1; nvalid = m_valid;
        if (PCSrc || (flushIF_ID && !(jump && pcstall))) begin
            ninstr = 16'h0000; np1 = inc; nvalid = 0;
        end else if (IF_IDstall || pcstall) begin
            // hold
        end else if (m_boot) begin
            ninstr = 16'h0000; np1 = inc; nvalid = 0;
        end else begin
            ninstr = mem_f(m_pc); np1 = inc; nvalid = 1;
        end

        ncnt = (m_sq && m_cnt != 16'hFFFF) ? 16'(m_cnt + 16'd1) : m_cnt;
        nboot = 0;
        if (m_boot)      nsq = 0;
        else if (m_sq)   nsq = pcstall || PCSrc;
        else             nsq = PCSrc;

        m_pc = npc; m_instr = ninstr; m_p1 = np1; m_valid = nvalid;
        m_boot = nboot; m_sq = nsq; m_cnt = ncnt;
    endtask

    task automatic step(input bit r, input bit ps, input bit ids, input bit fl,
                        input bit pcs, input logic [15:0] bt, input bit j,
                        input logic [15:0] jt, input string tag, input bit do_check);
        rst = r; pcstall = ps; IF_IDstall = ids; flushIF_ID = fl;
        PCSrc = pcs; branch_target = bt; jump = j; jump_target = jt;
        model_clock();
        @(posedge clk);
        #1;
        if (do_check) check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 16'h0, 0, 16'h0, tag, 1);
    endtask

    initial begin
        logic [15:0] pc_save, cnt_save, p1_save;
        rst = 1; pcstall = 0; IF_IDstall = 0; flushIF_ID = 0; PCSrc = 0;
        branch_target = '0; jump = 0; jump_target = '0;
        m_pc = '0; m_instr = '0; m_p1 = '0; m_valid = 0; m_boot = 1; m_sq = 0; m_cnt = '0;

        // reset
        step(1, 0, 0, 0, 0, 16'h0, 0, 16'h0, "reset", 1);
        check("reset.imem_en_const", imem_en, 1'b0);

        // 1: boot then free-run
        for (int unsigned k = 0; k < 4; k++) idle("t1");
        check("t1.pcF3", pcF, 16'h0003);
        check("t1.instr", instrD, 16'h1002);
        check("t1.valid", validD, 1'b1);

        // 2: pcstall at pcF=5
        idle("t2a"); idle("t2b");
        check("t2.pcF5", pcF, 16'h0005);
        p1_save = pcplus1D;
        step(0, 1, 0, 0, 0, 16'h0, 0, 16'h0, "t2.stall0", 1);
        step(0, 1, 0, 0, 0, 16'h0, 0, 16'h0, "t2.stall1", 1);
        check("t2.held_pc", pcF, 16'h0005);
        check("t2.held_p1", pcplus1D, p1_save);
        idle("t2.rel");
        check("t2.pcF6", pcF, 16'h0006);

        // 3: branch while stalled
        cnt_save = squash_cnt;
        step(0, 1, 0, 0, 1, 16'h0040, 0, 16'h0, "t3.br", 1);
        check("t3.pc40", pcF, 16'h0040);
        for (int unsigned k = 0; k < 3; k++)
            step(0, 1, 0, 0, 0, 16'h0, 0, 16'h0, "t3.stall", 1);
        check("t3.valid0", validD, 1'b0);
        idle("t3.exit");
        check("t3.cnt4", squash_cnt, 16'(cnt_save + 16'd4));
        check("t3.instr40", instrD, 16'h1040);
        check("t3.valid1", validD, 1'b1);

        // 4a: branch beats jump
        step(0, 0, 0, 0, 1, 16'h0080, 1, 16'h0020, "t4a", 1);
        check("t4a.pc80", pcF, 16'h0080);
        check("t4a.bubble", validD, 1'b0);
        idle("t4a.exit"); idle("t4a.run");

        // 4b: stalled jump survives flush, then is taken
        pc_save = pcF;
        step(0, 1, 0, 1, 0, 16'h0, 1, 16'h0020, "t4b", 1);
        check("t4b.pc_held", pcF, pc_save);
        check("t4b.valid_held", validD, 1'b1);
        step(0, 0, 0, 0, 0, 16'h0, 1, 16'h0020, "t4b.take", 1);
        check("t4b.pc20", pcF, 16'h0020);

        // 5: PC wrap
        step(0, 0, 0, 0, 1, 16'hFFFF, 0, 16'h0, "t5.br", 1);
        idle("t5.wrap");
        check("t5.pc0", pcF, 16'h0000);
        check("t5.p1", pcplus1D, 16'h0000);
        idle("t5.run");

        // 6: reset during SQUASH at squash_cnt=7
        step(1, 0, 0, 0, 0, 16'h0, 0, 16'h0, "t6.rst0", 1);
        idle("t6.boot"); idle("t6.run");
        step(0, 1, 0, 0, 1, 16'h0010, 0, 16'h0, "t6.br", 1);
        for (int unsigned k = 0; k < 20 && m_cnt != 16'd7; k++)
            step(0, 1, 0, 0, 0, 16'h0, 0, 16'h0, "t6.sq", 1);
        check("t6.cnt7", squash_cnt, 16'd7);
        step(1, 1, 0, 0, 0, 16'h0, 0, 16'h0, "t6.rst", 1);
        check("t6.cnt0", squash_cnt, 16'd0);
        check("t6.pc0", pcF, 16'h0000);
        check("t6.sq0", squashing, 1'b0);
        check("t6.en0", imem_en, 1'b0);

        // squash counter saturation
        idle("sat.boot");
        step(0, 1, 0, 0, 1, 16'h0030, 0, 16'h0, "sat.br", 1);
        for (int unsigned k = 0; k < 65540; k++)
            step(0, 1, 0, 0, 0, 16'h0, 0, 16'h0, "sat.run", 0);
        check_all("sat.end");
        check("sat.ffff", squash_cnt, 16'hFFFF);

        // random traffic
        for (int unsigned k = 0; k < 600; k++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, 16'($urandom),
                 $urandom_range(0, 5) == 0, 16'($urandom), "rand", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
